port_arbiter: RTL

Per-output-port round-robin arbiter for the mesh router; the grant-side counterpart of the request generator unit. It collects one request bit from each of the five input ports' request vectors and returns a one-cycle acknowledge to the winner, which clears that port's request register. It then holds the crossbar select for the granted input until the tail flit has left, and gates flit transfer on downstream buffer credits.

---
 rtl/port_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/port_arbiter.sv
// port_arbiter: per-output-port round-robin arbiter for the mesh router.
// Grants one of five input ports (X+, X-, Y+, Y-, PE) and sends the winner a
// one-cycle ack. It then holds the crossbar select until the tail flit leaves.
// Optional feature macro: ARB_CREDIT_EN. When defined, a downstream credit
// counter gates both the grant and out_en. When undefined, credit_in is
// ignored.
module port_arbiter #(
  parameter int BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rqs_in,
  input  logic       flit_xfer,
  input  logic       tail,
  input  logic       credit_in,
  output logic [4:0] ack_vector,
  output logic [4:0] xbar_sel,
  output logic       out_en
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr;        // round-robin priority pointer, 0..4
  logic [2:0] win_idx;    // registered winner, valid while BUSY
  logic       ack_pend;   // high only in the first BUSY cycle
  logic [2:0] grant_idx;
  logic       grant_found;
  logic       credit_ok;
  logic       can_grant;
  logic       accept;
  logic       tail_done;

`ifdef ARB_CREDIT_EN
  logic [CREDIT_WIDTH-1:0] credits;

  assign credit_ok = (credits != '0);

  // Credit counter: an accepted flit spends one credit, and credit_in returns
  // one. If both happen in the same cycle, the count is unchanged. Returns are
  // dropped once the count reaches BUFFER_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CREDIT_WIDTH'(BUFFER_DEPTH);
    end else begin
      case ({accept, credit_in})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   if (credits < CREDIT_WIDTH'(BUFFER_DEPTH)) credits <= credits + 1'b1;
        default: credits <= credits;
      endcase
    end
  end
`else
  logic unused_credit;
  assign unused_credit = credit_in;
  assign credit_ok     = 1'b1;
`endif

  // Round-robin scan: first set request at or above the pointer, wrapping 4->0.
  always_comb begin
    int idx;
    idx         = 0;
    grant_idx   = 3'd0;
    grant_found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idx = (int'(ptr) + i) % 5;
      if (!grant_found && rqs_in[idx]) begin
        grant_found = 1'b1;
        grant_idx   = 3'(idx);
      end
    end
  end

  assign can_grant = grant_found & credit_ok;
  assign accept    = flit_xfer & out_en;
  assign tail_done = accept & tail;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. Requests are only looked at while IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (can_grant) state_nxt = BUSY;
      BUSY:    if (tail_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. out_en follows the credit count in the same cycle.
  always_comb begin
    xbar_sel   = 5'b0;
    ack_vector = 5'b0;
    out_en     = 1'b0;
    if (state == BUSY) begin
      xbar_sel = 5'b00001 << win_idx;
      out_en   = credit_ok;
      if (ack_pend) ack_vector = 5'b00001 << win_idx;
    end
  end

  // Winner and pointer registers. The pointer advances past the winner when
  // the tail is accepted. A reset drops any pending ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 3'd0;
      win_idx  <= 3'd0;
      ack_pend <= 1'b0;
    end else begin
      ack_pend <= (state == IDLE) && can_grant;
      if (state == IDLE && can_grant) win_idx <= grant_idx;
      if (state == BUSY && tail_done) ptr <= (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
    end
  end

endmodule
